// File: rtl/mmio_responder_if.sv
// CPU-side memory bus between the RISC core and mmio_responder.
// Handshake: a command is valid while mem_cmd != NONE. The CPU holds
// mem_cmd/mem_addr/write_data stable until it sees the single-cycle
// resp_valid, then must return mem_cmd to NONE before it issues the next command.
interface mmio_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              resp_valid;
  logic              busy;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, resp_valid, busy
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, resp_valid, busy
  );
endinterface

// File: rtl/mmio_responder.sv
// Bus responder: decodes CPU commands to on-chip RAM or to the LEDR/TIMER/SW
// peripherals and answers each command with one registered resp_valid pulse.
module mmio_responder #(
  parameter int WAIT_STATES = 1,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  output logic [7:0]        ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [7:0]        sw_in,
  output logic [7:0]        ledr_out,
  output logic              bus_err,
  output logic [2:0]        dbg_state
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_LEDR  = ADDR_W'(9'h100);
  localparam logic [ADDR_W-1:0] ADDR_TIMER = ADDR_W'(9'h120);
  localparam logic [ADDR_W-1:0] ADDR_SW    = ADDR_W'(9'h140);

  localparam logic [2:0] WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        wait_cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_mux;
  logic [15:0]       timer;
  logic [7:0]        sw_meta, sw_sync;
  logic [7:0]        led_q;
  logic              err_q;
  logic              sel_ram, sel_led, sel_timer, sel_sw, sel_unmapped;
  logic              cmd_take, cmd_ill;
  logic              resp_valid_c, busy_c, ram_we_c;

  assign cmd_take = (bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE);
  assign cmd_ill  = (bus.mem_cmd == CMD_ILL);

  // Decode always works on the latched address so it is stable for the whole transaction.
  assign sel_ram      = ~lat_addr[8];
  assign sel_led      = (lat_addr == ADDR_LEDR);
  assign sel_timer    = (lat_addr == ADDR_TIMER);
  assign sel_sw       = (lat_addr == ADDR_SW);
  assign sel_unmapped = ~sel_ram & ~sel_led & ~sel_timer & ~sel_sw;

  always_comb begin
    rd_mux = '0;
    if (sel_ram)        rd_mux = ram_rdata;
    else if (sel_led)   rd_mux = DATA_W'(led_q);
    else if (sel_timer) rd_mux = DATA_W'(timer);
    else if (sel_sw)    rd_mux = DATA_W'(sw_sync);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    resp_valid_c = 1'b0;
    busy_c       = (state != S_IDLE);
    ram_we_c     = 1'b0;
    case (state)
      S_IDLE:   if (cmd_take) state_nxt = S_ACCESS;
      S_ACCESS: begin
        ram_we_c  = lat_write & sel_ram;
        state_nxt = S_FETCH;
      end
      S_FETCH:  state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = S_RESP;
      S_RESP: begin
        resp_valid_c = 1'b1;
        state_nxt    = S_HOLD;
      end
      // A command still asserted after the response is the same command, never a new one.
      S_HOLD:   if (bus.mem_cmd == CMD_NONE) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
    else wait_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == S_IDLE && cmd_take) begin
      lat_write <= (bus.mem_cmd == CMD_WRITE);
      lat_addr  <= bus.mem_addr;
      lat_wdata <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ACCESS && lat_write && sel_led) led_q <= lat_wdata[7:0];
      if ((state == S_ACCESS && sel_unmapped) || (state == S_IDLE && cmd_ill)) err_q <= 1'b1;
    end
  end

  // A clear write wins over the free-running increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer <= '0;
    else if (state == S_ACCESS && lat_write && sel_timer) timer <= '0;
    else timer <= timer + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else if (state == S_FETCH && !lat_write) rd_data_q <= rd_mux;
  end

  assign bus.read_data  = rd_data_q;
  assign bus.resp_valid = resp_valid_c;
  assign bus.busy       = busy_c;
  assign ram_addr       = lat_addr[7:0];
  assign ram_we         = ram_we_c;
  assign ram_wdata      = lat_wdata;
  assign ledr_out       = led_q;
  assign bus_err        = err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: a driver issues commands and pushes the
// expected read_data into exp_q; a negedge monitor pops and compares on resp_valid.
module tb_mmio_responder;
  localparam int WS     = 1;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam logic [1:0] C_NONE = 2'b00, C_READ = 2'b01, C_WRITE = 2'b10, C_ILL = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [7:0]        sw_in;
  logic [7:0]        ledr_out;
  logic              bus_err;
  logic [2:0]        dbg_state;

  mmio_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mmio_responder #(.WAIT_STATES(WS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .ledr_out(ledr_out), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external synchronous RAM model, read-first
  logic [DATA_W-1:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;
  logic [DATA_W-1:0] model_rd = '0;
  int n_cmp = 0, n_err = 0;
  int resp_cnt = 0, we_cnt = 0;
  int timer_clr_cap = 0;
  logic [7:0]        last_we_addr = '0;
  logic [DATA_W-1:0] last_we_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got read_data 0x%0h, expected no response", bus.read_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp_read_data", 32'(bus.read_data), 32'(mon_exp));
      end
    end
    if (ram_we === 1'b1) begin
      we_cnt++;
      last_we_addr = ram_addr;
      last_we_data = ram_wdata;
    end
  end

  // driver tasks
  task automatic txn(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wdata,
                     input logic [15:0] exp_rd, input bit timer_rd, input int hold_extra,
                     input bit sw_chg, input logic [7:0] sw_val);
    int cap;
    int lat;
    bit seen;
    logic [15:0] e;
    @(negedge clk);
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = wdata;
    @(posedge clk);
    #1 cap = cyc;
    if (cmd == C_WRITE && addr == 9'h120) timer_clr_cap = cap;
    if (cmd == C_READ) begin
      e = timer_rd ? 16'(cap - timer_clr_cap) : exp_rd;
      model_rd = e;
    end else begin
      e = model_rd;
    end
    exp_q.push_back(e);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_in_access", 32'(bus.busy), 32'd1);
        if (sw_chg) sw_in = sw_val;
      end
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    check("resp_latency", 32'(lat), 32'(3 + WS));
    repeat (hold_extra) @(negedge clk);
    bus.mem_cmd = C_NONE;
    @(negedge clk);
  endtask

  task automatic rd(input logic [8:0] addr, input logic [15:0] exp_rd);
    txn(C_READ, addr, 16'h0000, exp_rd, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] wdata);
    txn(C_WRITE, addr, wdata, 16'h0000, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bus.mem_cmd = C_NONE;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_rd = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we0, rc;

    // reset held with a READ pending
    reset          = 1'b0;
    sw_in          = 8'h00;
    bus.mem_cmd    = C_READ;
    bus.mem_addr   = 9'h009;
    bus.write_data = 16'h0000;
    rc = resp_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    check("reset_read_data", 32'(bus.read_data), 32'd0);
    check("reset_ledr", 32'(ledr_out), 32'd0);
    check("reset_bus_err", 32'(bus_err), 32'd0);
    check("reset_ram_addr", 32'(ram_addr), 32'd0);
    check("reset_ram_we", 32'(ram_we), 32'd0);
    check("reset_ram_wdata", 32'(ram_wdata), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    bus.mem_cmd = C_NONE;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy_after_release", 32'(bus.busy), 32'd0);
    check("no_resp_during_reset", 32'(resp_cnt - rc), 32'd0);

    // RAM round trip
    we0 = we_cnt;
    wr(9'h009, 16'h0030);
    check("ram_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("ram_we_addr", 32'(last_we_addr), 32'h09);
    check("ram_we_data", 32'(last_we_data), 32'h0030);
    rd(9'h009, 16'h0030);

    // LEDR
    we0 = we_cnt;
    wr(9'h100, 16'hABCD);
    check("ledr_value", 32'(ledr_out), 32'hCD);
    check("ledr_no_ram_we", 32'(we_cnt - we0), 32'd0);
    rd(9'h100, 16'h00CD);

    // SW through the synchronizer
    sw_in = 8'h5A;
    repeat (4) @(negedge clk);
    rd(9'h140, 16'h005A);
    txn(C_READ, 9'h140, 16'h0000, 16'h005A, 1'b0, 0, 1'b1, 8'h11);
    rd(9'h140, 16'h0011);

    // command held long after the response
    rc  = resp_cnt;
    we0 = we_cnt;
    txn(C_READ, 9'h009, 16'h0000, 16'h0030, 1'b0, 10, 1'b0, 8'h00);
    check("held_cmd_single_resp", 32'(resp_cnt - rc), 32'd1);
    check("held_cmd_no_ram_we", 32'(we_cnt - we0), 32'd0);
    check("held_cmd_idle_after", 32'(bus.busy), 32'd0);

    // timer clear, then elapsed count
    wr(9'h120, 16'h1234);
    check("timer_write_led_untouched", 32'(ledr_out), 32'hCD);
    repeat (7) @(negedge clk);
    txn(C_READ, 9'h120, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 8'h00);

    // SW write is ignored and mapped, so no error
    wr(9'h140, 16'hFFFF);
    rd(9'h140, 16'h0011);
    check("no_err_yet", 32'(bus_err), 32'd0);

    // illegal command in IDLE
    rc = resp_cnt;
    @(negedge clk);
    bus.mem_cmd = C_ILL;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("illegal_busy", 32'(bus.busy), 32'd0);
    end
    bus.mem_cmd = C_NONE;
    check("illegal_bus_err", 32'(bus_err), 32'd1);
    check("illegal_no_resp", 32'(resp_cnt - rc), 32'd0);

    reset_pulse();
    check("err_cleared_by_reset", 32'(bus_err), 32'd0);
    check("led_cleared_by_reset", 32'(ledr_out), 32'd0);

    // unmapped accesses
    rd(9'h1F0, 16'h0000);
    check("unmapped_bus_err", 32'(bus_err), 32'd1);
    we0 = we_cnt;
    wr(9'h1F0, 16'h00FF);
    check("unmapped_wr_led", 32'(ledr_out), 32'd0);
    check("unmapped_wr_no_we", 32'(we_cnt - we0), 32'd0);
    rd(9'h009, 16'h0030);
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // reset during WAIT
    rc = resp_cnt;
    @(negedge clk);
    bus.mem_cmd  = C_READ;
    bus.mem_addr = 9'h009;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_resp_valid", 32'(bus.resp_valid), 32'd0);
    bus.mem_cmd = C_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_rd = '0;
    repeat (4) @(negedge clk);
    check("midreset_no_resp", 32'(resp_cnt - rc), 32'd0);
    check("midreset_read_data", 32'(bus.read_data), 32'd0);
    check("midreset_bus_err", 32'(bus_err), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Bus responder on the far end of the CPU memory interface.
- Accepts read/write commands from the CPU on mem_cmd/mem_addr/write_data. Decodes each address to on-chip RAM or to memory-mapped peripherals (LEDR, SW, timer). Returns read data with a one-cycle resp_valid pulse.
- Sits in RISC_top between CPU and MEM/board I/O and replaces the ad-hoc combinational LEDR/SW decode.

Parameters:
- WAIT_STATES, 1, extra response-delay cycles inserted after the fetch cycle; legal range 0..7.
- DATA_W, 16, bus data width.
- ADDR_W, 9, bus address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_cmd  in  2  00 NONE, 01 READ, 10 WRITE, 11 illegal.
- mem_addr  in  ADDR_W  request address; held stable by CPU until resp_valid.
- write_data  in  DATA_W  write payload; held stable with mem_addr.
- read_data  out  DATA_W  registered read result.
- resp_valid  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- ram_addr  out  8  RAM word address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM synchronous read data; valid the cycle after the address is presented.
- sw_in  in  8  raw board switches (asynchronous).
- ledr_out  out  8  LED register.
- bus_err  out  1  sticky error flag.

Behaviour:
- Address map:
  - addr[8]=0: RAM, word addr[7:0].
  - 0x100: LEDR. Write stores write_data[7:0]. Read returns {8'h00, led}.
  - 0x120: TIMER. Read returns the counter. Write clears it.
  - 0x140: SW. Read returns {8'h00, sw_sync}. Write is ignored.
  - Any other address ≥0x100 is unmapped: read returns 0, write is ignored, bus_err is set.
- FSM states: IDLE, ACCESS, FETCH, WAIT, RESP, HOLD.
- IDLE:
  - mem_cmd READ/WRITE at a rising edge: latch cmd/addr/wdata and go to ACCESS.
  - mem_cmd 11: stay in IDLE, set bus_err, no response.
  - mem_cmd NONE: stay in IDLE.
- ACCESS (1 cycle):
  - ram_addr = latched addr[7:0] in every state (0 in IDLE after reset).
  - ram_we = 1 only in ACCESS and only for a RAM write; exactly one pulse per write.
  - LED and TIMER writes commit at the edge ending ACCESS.
  - Go to FETCH.
- FETCH (1 cycle): read_data is loaded at the edge ending FETCH with the decoded source (ram_rdata, led, timer, sw_sync, or 0). Writes leave read_data unchanged. Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: stay exactly WAIT_STATES cycles, then go to RESP.
- RESP (1 cycle): resp_valid = 1, then go to HOLD.
- HOLD: wait until mem_cmd == NONE, then go to IDLE. A command held past RESP never produces a duplicate access.
- Latency: resp_valid is high in cycle 3+WAIT_STATES counting the capture cycle as cycle 1. With the default WAIT_STATES=1, that is cycle 4. Back-to-back minimum spacing is 5+WAIT_STATES cycles.
- Timer:
  - 16-bit free-running counter, +1 every cycle, wraps 0xFFFF→0x0000.
  - A write clear takes priority over the increment in the same cycle.
- SW: two-flop synchronizer, reset 0. The value read is the sw_sync value at the FETCH edge.
- bus_err: set by an unmapped access (at the ACCESS edge) or by an illegal cmd in IDLE. Cleared only by reset.
- Reset (asynchronous, any state including mid-transaction):
  - State returns to IDLE immediately.
  - ram_we=0 immediately; no partial write.
  - resp_valid=0, busy=0.
  - read_data, ledr_out, timer, sw_sync, bus_err, ram_addr, ram_wdata all 0.

Test Plan:
- Reset: hold reset low with mem_cmd=READ addr 0x009 for 5 cycles → all outputs 0, busy=0, no resp_valid. Release → IDLE, busy rises only on the next command.
- RAM round-trip (WAIT_STATES=1):
  - WRITE 0x009 data 0x0030 → one ram_we pulse, ram_addr=0x09, ram_wdata=0x0030.
  - Then READ 0x009 with the model RAM returning 0x0030 → resp_valid high exactly in cycle 4 after capture, read_data=0x0030.
- LEDR: WRITE 0x100 data 0xABCD → ledr_out=0xCD after the ACCESS edge, no ram_we. READ 0x100 → read_data=0x00CD.
- SW:
  - sw_in=0x5A stable → READ 0x140 returns 0x005A.
  - sw_in toggled to 0x11 one cycle before the FETCH edge → READ returns 0x005A (synchronizer delay).
- Errors:
  - READ 0x1F0 → read_data=0x0000, resp_valid pulses, bus_err=1 and stays 1 across later good transactions.
  - mem_cmd=11 in IDLE → no busy, no resp_valid, bus_err=1.
- Handshake and reset edge cases:
  - mem_cmd held READ for 10 cycles after resp_valid → exactly one resp_valid and one RAM access.
  - Timer WRITE clears the counter to 0; a later READ returns the elapsed cycle count.
  - reset asserted during WAIT → immediate IDLE, resp_valid never pulses.
